// File: rtl/toggle_edge_counter.sv
// Counts rising edges of a toggle-counter output as a modulo-(MAX+1) count.
// A small run/halt FSM gates counting, and a one-cycle carry marks each wrap.
module toggle_edge_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MAX   = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             toggle_in,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             carry,
   output logic             running
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StHalt = 2'b10
   } state_e;

   localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MAX);

   state_e           state_q, state_d;
   logic             in_q;
   logic [WIDTH-1:0] count_q, count_d;
   logic             carry_q, carry_d;
   logic             running_q, running_d;
   logic             rise;

   assign rise = toggle_in & ~in_q;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      carry_d = 1'b0;
      if (clear) begin
         // Clear wins over everything, including a coincident rise.
         state_d = StIdle;
         count_d = '0;
      end else begin
         case (state_q)
            StIdle: begin
               count_d = '0;
               if (start) state_d = StRun;
            end
            StRun: begin
               if (rise) begin
                  if (count_q == MaxCount) begin
                     count_d = '0;
                     carry_d = 1'b1;
                  end else begin
                     count_d = count_q + WIDTH'(1);
                  end
               end
               if (stop && !start) state_d = StHalt;
            end
            StHalt: begin
               if (start) state_d = StRun;
            end
            default: begin
               state_d = StIdle;
               count_d = '0;
            end
         endcase
      end
      running_d = (state_d == StRun);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         in_q      <= 1'b0;
         count_q   <= '0;
         carry_q   <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_q      <= toggle_in;
         count_q   <= count_d;
         carry_q   <= carry_d;
         running_q <= running_d;
      end
   end

   assign count   = count_q;
   assign carry   = carry_q;
   assign running = running_q;

endmodule
